bus_if_addr_demux: RTL



---
 rtl/bus_if_addr_demux.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bus_if_addr_demux.sv
// bus_if_addr_demux
//   Address-decoding splitter: one upstream master port fans out to two
//   downstream slave ports. A 1-bit tag queue remembers which slave owns
//   each accepted command so that responses reach the master in issue
//   order, with up to NUM_IN_FLIGHT commands outstanding.
//
// Ports
//   in_clk, in_mreset_n       : clock and async active-low reset (from master)
//   in_mcmd/maddr/mdata/mbyteen, in_scmdaccept : upstream request channel
//   in_sresp/sdata, in_mrespaccept             : upstream response channel
//   out_0_* : default region (request, response, reset)
//   out_1_* : region selected when (in_maddr & MASK_1) == BASE_1
module bus_if_addr_demux #(
    parameter logic [31:0] BASE_1        = 32'h8000_0000,
    parameter logic [31:0] MASK_1        = 32'h8000_0000,
    parameter int          NUM_IN_FLIGHT = 4
) (
    input  logic        in_clk,
    input  logic        in_mreset_n,
    input  logic [2:0]  in_mcmd,
    input  logic [31:0] in_maddr,
    input  logic [31:0] in_mdata,
    input  logic [3:0]  in_mbyteen,
    output logic        in_scmdaccept,
    output logic [1:0]  in_sresp,
    output logic [31:0] in_sdata,
    input  logic        in_mrespaccept,

    output logic        out_0_mreset_n,
    output logic [2:0]  out_0_mcmd,
    output logic [31:0] out_0_maddr,
    output logic [31:0] out_0_mdata,
    output logic [3:0]  out_0_mbyteen,
    input  logic        out_0_scmdaccept,
    input  logic [1:0]  out_0_sresp,
    input  logic [31:0] out_0_sdata,
    output logic        out_0_mrespaccept,

    output logic        out_1_mreset_n,
    output logic [2:0]  out_1_mcmd,
    output logic [31:0] out_1_maddr,
    output logic [31:0] out_1_mdata,
    output logic [3:0]  out_1_mbyteen,
    input  logic        out_1_scmdaccept,
    input  logic [1:0]  out_1_sresp,
    input  logic [31:0] out_1_sdata,
    output logic        out_1_mrespaccept
);

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [1:0] RESP_NULL = 2'd0;

    localparam int PTR_W = $clog2(NUM_IN_FLIGHT);
    localparam int CNT_W = $clog2(NUM_IN_FLIGHT + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_IN_FLIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_IN_FLIGHT);

    logic [NUM_IN_FLIGHT-1:0] tags;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;

    logic       sel;
    logic       head;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic [1:0] head_sresp;

    assign out_0_mreset_n = in_mreset_n;
    assign out_1_mreset_n = in_mreset_n;

    assign sel   = ((in_maddr & MASK_1) == BASE_1);
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign head  = tags[rd_ptr];

    assign head_sresp = head ? out_1_sresp : out_0_sresp;
    assign push       = in_scmdaccept;
    assign pop        = !empty && in_mrespaccept && (head_sresp != RESP_NULL);

    always_comb begin
        out_0_mcmd    = CMD_IDLE;
        out_0_maddr   = '0;
        out_0_mdata   = '0;
        out_0_mbyteen = '0;
        out_1_mcmd    = CMD_IDLE;
        out_1_maddr   = '0;
        out_1_mdata   = '0;
        out_1_mbyteen = '0;

        // A full queue has no slot for the tag, so nothing is offered downstream.
        if (!full) begin
            if (sel) begin
                out_1_mcmd    = in_mcmd;
                out_1_maddr   = in_maddr;
                out_1_mdata   = in_mdata;
                out_1_mbyteen = in_mbyteen;
            end else begin
                out_0_mcmd    = in_mcmd;
                out_0_maddr   = in_maddr;
                out_0_mdata   = in_mdata;
                out_0_mbyteen = in_mbyteen;
            end
        end

        in_scmdaccept = !full && (in_mcmd != CMD_IDLE) &&
                        (sel ? out_1_scmdaccept : out_0_scmdaccept);

        // Only the slave owning the oldest tag may hand back a response;
        // the other one holds its response until it becomes head.
        in_sresp          = RESP_NULL;
        in_sdata          = '0;
        out_0_mrespaccept = 1'b0;
        out_1_mrespaccept = 1'b0;
        if (!empty) begin
            if (head) begin
                in_sresp          = out_1_sresp;
                in_sdata          = out_1_sdata;
                out_1_mrespaccept = in_mrespaccept;
            end else begin
                in_sresp          = out_0_sresp;
                in_sdata          = out_0_sdata;
                out_0_mrespaccept = in_mrespaccept;
            end
        end
    end

    // Tag storage needs no reset: entries are only read below count.
    always_ff @(posedge in_clk) begin
        if (push) begin
            tags[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge in_clk or negedge in_mreset_n) begin
        if (!in_mreset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
